output_port_arbiter: RTL and testbench

Output-side responder for the router's per-input arbitration requests. Each input port raises a start request carrying 10-bit source and destination addresses. This block latches every request and grants one input at a time using round-robin order. It holds the grant until the winning input releases it, or until a watchdog expires. It sits between the input-port request logic and one output port's crossbar select.

---
 rtl/output_port_arbiter.sv | 125 ++++++++++++
 tb/tb_output_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_arbiter.sv
// Round-robin arbiter that serves per-input start requests for one output port.
// Grants are held until the winner releases or the hold watchdog expires.
module output_port_arbiter #(
    parameter int NUM_IN      = 5,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN-1:0]        router_start_req,
    input  logic [NUM_IN*ADDR_W-1:0] router_scr_addr,
    input  logic [NUM_IN*ADDR_W-1:0] router_dst_addr,
    input  logic [NUM_IN-1:0]        pkt_release,
    output logic [NUM_IN-1:0]        req_ack,
    output logic [NUM_IN-1:0]        req_err,
    output logic [NUM_IN-1:0]        grant,
    output logic                     grant_valid,
    output logic [ADDR_W-1:0]        grant_scr_addr,
    output logic [ADDR_W-1:0]        grant_dst_addr,
    output logic                     timeout,
    output logic                     busy
);

    localparam int PW = $clog2(NUM_IN);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic [NUM_IN-1:0]   start_prev;
    logic [NUM_IN-1:0]   pending;
    logic [NUM_IN-1:0]   new_req;
    logic [NUM_IN-1:0]   clr;
    logic [NUM_IN-1:0]   accept;
    logic [ADDR_W-1:0]   src_q [NUM_IN];
    logic [ADDR_W-1:0]   dst_q [NUM_IN];
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       win_idx;
    logic                win_found;
    logic [7:0]          hold_cnt;

    // Scan starts one past the last winner and wraps modulo NUM_IN.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            if (!win_found && pending[PW'((int'(rr_ptr) + k) % NUM_IN)]) begin
                win_found = 1'b1;
                win_idx   = PW'((int'(rr_ptr) + k) % NUM_IN);
            end
        end
    end

    assign new_req     = router_start_req & ~start_prev;
    assign clr         = (state == IDLE && win_found) ?
                         (NUM_IN'(1) << win_idx) : '0;
    // A winner's slot frees this cycle, so a coincident edge is accepted.
    assign accept      = new_req & (~pending | clr);
    assign grant_valid = |grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            start_prev     <= '0;
            pending        <= '0;
            rr_ptr         <= PW'(NUM_IN - 1);
            hold_cnt       <= '0;
            req_ack        <= '0;
            req_err        <= '0;
            grant          <= '0;
            grant_scr_addr <= '0;
            grant_dst_addr <= '0;
            timeout        <= 1'b0;
            busy           <= 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                src_q[i] <= '0;
                dst_q[i] <= '0;
            end
        end else begin
            start_prev <= router_start_req;
            req_ack    <= accept;
            req_err    <= new_req & ~accept;
            timeout    <= 1'b0;
            pending    <= (pending & ~clr) | accept;
            for (int i = 0; i < NUM_IN; i++) begin
                if (accept[i]) begin
                    src_q[i] <= router_scr_addr[i*ADDR_W +: ADDR_W];
                    dst_q[i] <= router_dst_addr[i*ADDR_W +: ADDR_W];
                end
            end
            unique case (state)
                IDLE: begin
                    if (win_found) begin
                        grant          <= clr;
                        grant_scr_addr <= src_q[win_idx];
                        grant_dst_addr <= dst_q[win_idx];
                        rr_ptr         <= win_idx;
                        hold_cnt       <= '0;
                        busy           <= 1'b1;
                        state          <= BUSY;
                    end
                end
                BUSY: begin
                    if (pkt_release[rr_ptr]) begin
                        grant          <= '0;
                        grant_scr_addr <= '0;
                        grant_dst_addr <= '0;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end else if (hold_cnt == 8'(TIMEOUT_CYC - 1)) begin
                        grant          <= '0;
                        grant_scr_addr <= '0;
                        grant_dst_addr <= '0;
                        busy           <= 1'b0;
                        timeout        <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed scenarios plus random traffic,
// all cycles compared against a behavioural request/grant model.
module tb_output_port_arbiter;

    localparam int N  = 5;
    localparam int AW = 10;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    start = '0;
    logic [N-1:0]    rel = '0;
    logic [N*AW-1:0] sa = '0;
    logic [N*AW-1:0] da = '0;
    logic [N-1:0]    req_ack, req_err, grant;
    logic            grant_valid, timeout, busy;
    logic [AW-1:0]   grant_scr_addr, grant_dst_addr;

    always #5 clk = ~clk;

    output_port_arbiter #(.NUM_IN(N), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .router_start_req(start),
        .router_scr_addr(sa), .router_dst_addr(da),
        .pkt_release(rel),
        .req_ack(req_ack), .req_err(req_err),
        .grant(grant), .grant_valid(grant_valid),
        .grant_scr_addr(grant_scr_addr), .grant_dst_addr(grant_dst_addr),
        .timeout(timeout), .busy(busy)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: who holds the port, who is waiting, what they asked.
    int            m_gnt = -1;
    int            m_last = N - 1;
    int            m_held = 0;
    bit            m_pend [N];
    bit            m_prev [N];
    logic [AW-1:0] m_src [N];
    logic [AW-1:0] m_dst [N];
    logic [N-1:0]  e_ack = '0, e_err = '0;
    logic [AW-1:0] e_gsrc = '0, e_gdst = '0;
    logic          e_to = 1'b0;

    task automatic model_step();
        int w;
        if (!rst_n) begin
            m_gnt = -1; m_last = N - 1; m_held = 0;
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_prev[i] = 0; m_src[i] = '0; m_dst[i] = '0;
            end
            e_ack = '0; e_err = '0; e_gsrc = '0; e_gdst = '0; e_to = 0;
            return;
        end
        e_to = 0;
        w = -1;
        if (m_gnt < 0) begin
            for (int k = 1; k <= N; k++)
                if (w < 0 && m_pend[(m_last + k) % N]) w = (m_last + k) % N;
            if (w >= 0) begin
                m_gnt = w; m_last = w; m_held = 1;
                e_gsrc = m_src[w]; e_gdst = m_dst[w];
                m_pend[w] = 0;
            end
        end else if (rel[m_gnt]) begin
            m_gnt = -1; e_gsrc = '0; e_gdst = '0;
        end else if (m_held == TO) begin
            m_gnt = -1; e_gsrc = '0; e_gdst = '0; e_to = 1;
        end else begin
            m_held++;
        end
        for (int i = 0; i < N; i++) begin
            e_ack[i] = 0; e_err[i] = 0;
            if (start[i] && !m_prev[i]) begin
                if (!m_pend[i]) begin
                    m_pend[i] = 1; e_ack[i] = 1;
                    m_src[i] = sa[i*AW +: AW]; m_dst[i] = da[i*AW +: AW];
                end else begin
                    e_err[i] = 1;
                end
            end
            m_prev[i] = start[i];
        end
    endtask

    typedef struct { int idx; int src; int dst; int on; int off; } gent_t;
    gent_t        glog [$];
    int           cyc = 0;
    int           ack_cnt [N];
    int           err_cnt [N];
    int           to_cnt = 0;
    logic [N-1:0] prev_g = '0;

    function automatic int idx_of(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    function automatic int g_idx(input int k);
        return (k < glog.size()) ? glog[k].idx : -1;
    endfunction
    function automatic int g_src(input int k);
        return (k < glog.size()) ? glog[k].src : -1;
    endfunction
    function automatic int g_dst(input int k);
        return (k < glog.size()) ? glog[k].dst : -1;
    endfunction
    function automatic int g_on(input int k);
        return (k < glog.size()) ? glog[k].on : -1;
    endfunction
    function automatic int g_off(input int k);
        return (k < glog.size()) ? glog[k].off : -1;
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] eg;
        gent_t e;
        #1;
        cyc++;
        model_step();
        eg = (m_gnt < 0) ? '0 : (N'(1) << m_gnt);
        chk("grant", grant, eg);
        chk("grant_valid", grant_valid, m_gnt >= 0);
        chk("busy", busy, m_gnt >= 0);
        chk("grant_scr_addr", grant_scr_addr, e_gsrc);
        chk("grant_dst_addr", grant_dst_addr, e_gdst);
        chk("req_ack", req_ack, e_ack);
        chk("req_err", req_err, e_err);
        chk("timeout", timeout, e_to);
        chk("grant_onehot0", $onehot0(grant), 1'b1);
        for (int i = 0; i < N; i++) begin
            if (req_ack[i]) ack_cnt[i]++;
            if (req_err[i]) err_cnt[i]++;
        end
        if (timeout) to_cnt++;
        if (grant != 0 && prev_g == 0) begin
            e.idx = idx_of(grant); e.src = int'(grant_scr_addr);
            e.dst = int'(grant_dst_addr); e.on = cyc; e.off = -1;
            glog.push_back(e);
        end else if (grant == 0 && prev_g != 0 && glog.size() > 0) begin
            e = glog.pop_back();
            e.off = cyc;
            glog.push_back(e);
        end
        prev_g = grant;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_stats();
        glog.delete();
        to_cnt = 0;
        for (int i = 0; i < N; i++) begin ack_cnt[i] = 0; err_cnt[i] = 0; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = '0; rel = '0;
        cycles(2);
        rst_n = 1'b1;
        clear_stats();
    endtask

    task automatic set_addr(input int i, input int s, input int d);
        sa[i*AW +: AW] = AW'(s);
        da[i*AW +: AW] = AW'(d);
    endtask

    task automatic release_when_granted(input int i, input int budget);
        bit done = 0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (grant[i]) begin
                rel[i] = 1'b1;
                @(negedge clk);
                rel[i] = 1'b0;
                done = 1;
            end
        end
        chk($sformatf("grant_wait_%0d", i), done, 1'b1);
    endtask

    task automatic wait_any_grant(input int budget, output int g);
        g = -1;
        for (int k = 0; k < budget && g < 0; k++) begin
            @(negedge clk);
            if (grant != 0) g = idx_of(grant);
        end
        chk("any_grant_wait", g >= 0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt2;
        int g;
        cycles(2);
        chk("rst_grant", grant, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", req_ack, '0);
        rst_n = 1'b1;
        clear_stats();

        // single request
        do_reset();
        cycles(1);
        set_addr(0, 'h001, 'h005);
        start[0] = 1'b1;
        cycles(2);
        start[0] = 1'b0;
        cycles(3);
        chk("s1_grant", grant, 5'b00001);
        chk("s1_src", grant_scr_addr, 10'h001);
        chk("s1_dst", grant_dst_addr, 10'h005);
        release_when_granted(0, 20);
        cycles(2);
        chk("s1_grant_clear", grant, '0);
        chk("s1_nlog", glog.size(), 1);
        chk("s1_ack", ack_cnt[0], 1);
        chk("s1_err", err_cnt[0], 0);

        // simultaneous requests
        do_reset();
        set_addr(1, 'h002, 'h010);
        set_addr(3, 'h004, 'h020);
        start[1] = 1'b1; start[3] = 1'b1;
        release_when_granted(1, 20);
        release_when_granted(3, 20);
        cycles(2);
        start = '0;
        chk("s2_first", g_idx(0), 1);
        chk("s2_second", g_idx(1), 3);
        chk("s2_src", g_src(1), 'h004);
        chk("s2_dst", g_dst(1), 'h020);
        chk("s2_gap", g_on(1) - g_off(0), 1);

        // fairness between inputs 0 and 4
        do_reset();
        set_addr(0, 'h0A0, 'h0A1);
        set_addr(4, 'h0B0, 'h0B1);
        start[0] = 1'b1; start[4] = 1'b1;
        for (int r = 0; r < 6; r++) begin
            wait_any_grant(30, g);
            if (g >= 0) begin
                rel[g] = 1'b1; start[g] = 1'b0;
                @(negedge clk);
                rel[g] = 1'b0; start[g] = 1'b1;
            end
        end
        for (int k = 0; k < 6; k++)
            chk($sformatf("s3_round%0d", k), g_idx(k), (k % 2 == 0) ? 0 : 4);

        // duplicate edge while pending
        do_reset();
        set_addr(0, 'h007, 'h008);
        start[0] = 1'b1;
        cycles(3);
        set_addr(2, 'h033, 'h044);
        start[2] = 1'b1;
        cycles(1);
        start[2] = 1'b0;
        cycles(1);
        set_addr(2, 'h3FF, 'h3FE);
        start[2] = 1'b1;
        cycles(1);
        start[2] = 1'b0;
        release_when_granted(0, 20);
        release_when_granted(2, 20);
        cycles(2);
        start = '0;
        cnt2 = 0;
        foreach (glog[k]) if (glog[k].idx == 2) cnt2++;
        chk("s4_ack2", ack_cnt[2], 1);
        chk("s4_err2", err_cnt[2], 1);
        chk("s4_grants2", cnt2, 1);
        chk("s4_src", g_src(1), 'h033);
        chk("s4_dst", g_dst(1), 'h044);

        // watchdog revokes a grant that is never released
        do_reset();
        set_addr(0, 'h0AA, 'h0BB);
        start[0] = 1'b1;
        cycles(3);
        set_addr(1, 'h011, 'h022);
        start[1] = 1'b1;
        release_when_granted(1, 30);
        cycles(2);
        start = '0;
        chk("s5_to_cnt", to_cnt, 1);
        chk("s5_first", g_idx(0), 0);
        chk("s5_hold", g_off(0) - g_on(0), TO);
        chk("s5_next", g_idx(1), 1);
        chk("s5_next_src", g_src(1), 'h011);
        chk("s5_gap", g_on(1) - g_off(0), 1);

        // reset while busy with another request pending
        do_reset();
        set_addr(0, 'h0C0, 'h0C1);
        start[0] = 1'b1;
        cycles(3);
        set_addr(3, 'h0D0, 'h0D1);
        start[3] = 1'b1;
        cycles(2);
        chk("s6_busy_before", busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b0; start = '0;
        #1;
        chk("s6_grant_rst", grant, '0);
        chk("s6_busy_rst", busy, 1'b0);
        chk("s6_valid_rst", grant_valid, 1'b0);
        cycles(2);
        rst_n = 1'b1;
        clear_stats();
        cycles(10);
        chk("s6_no_grant", glog.size(), 0);
        start[3] = 1'b1;
        release_when_granted(3, 20);
        chk("s6_regrant", g_idx(0), 3);
        chk("s6_regrant_src", g_src(0), 'h0D0);
        start = '0;

        // random traffic
        do_reset();
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 599) != 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) start[i] = ~start[i];
                if ($urandom_range(0, 3) == 0)
                    set_addr(i, $urandom_range(0, 1023), $urandom_range(0, 1023));
            end
            rel = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 4) == 0) rel = rel | grant;
        end
        @(negedge clk);
        rst_n = 1'b1; rel = '0; start = '0;
        cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
